// File: rtl/pipelined_cla_adder_if.sv
// pipelined_cla_adder_if: operand/result handshake bundle for pipelined_cla_adder (overflow present with CLA_OVERFLOW_EN)
interface pipelined_cla_adder_if #(parameter int WIDTH = 16);
  logic in_valid, in_ready, cin, out_valid, out_ready, cout;
  logic [WIDTH-1:0] a, b, sum;
`ifdef CLA_OVERFLOW_EN
  logic overflow;
  modport master (output in_valid, a, b, cin, out_ready, input in_ready, out_valid, sum, cout, overflow);
  modport slave (input in_valid, a, b, cin, out_ready, output in_ready, out_valid, sum, cout, overflow);
`else
  modport master (output in_valid, a, b, cin, out_ready, input in_ready, out_valid, sum, cout);
  modport slave (input in_valid, a, b, cin, out_ready, output in_ready, out_valid, sum, cout);
`endif
endinterface

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: 2-stage two-level carry look-ahead adder with valid/ready; CLA_OVERFLOW_EN adds signed overflow
module pipelined_cla_adder #(
  parameter int WIDTH   = 16,
  parameter int GROUP_W = 4
) (
  input logic clk,
  input logic rst,
  pipelined_cla_adder_if.slave bus
);
  localparam int NG = WIDTH / GROUP_W;
  if (WIDTH % GROUP_W != 0 || WIDTH < GROUP_W) begin : g_bad_cfg
    $fatal(1, "pipelined_cla_adder: WIDTH must be a non-zero multiple of GROUP_W");
  end
  logic s1_valid, s1_cin, s2_valid, s1_adv, s2_adv;
  logic [WIDTH-1:0] s1_p, s1_g, p, g, bc, sum_q;
  logic [NG-1:0] s1_gp, s1_gg, gp, gg;
  logic [NG:0] gc;
  logic cout_q, t1, t2, t3, a2, a3;
  assign s2_adv = !s2_valid || bus.out_ready;
  assign s1_adv = !s1_valid || s2_adv;
  assign bus.in_ready = s1_adv && !rst;
  assign bus.out_valid = s2_valid;
  assign bus.sum = sum_q;
  assign bus.cout = cout_q;
  // Stage 1: bit propagate/generate plus each group's propagate and lookahead generate
  always_comb begin
    p = bus.a ^ bus.b;
    g = bus.a & bus.b;
    gp = '0;
    gg = '0;
    t1 = 1'b0;
    for (int k = 0; k < NG; k++) begin
      gp[k] = &p[k*GROUP_W +: GROUP_W];
      for (int j = 0; j < GROUP_W; j++) begin
        t1 = g[k*GROUP_W+j];
        for (int m = j + 1; m < GROUP_W; m++) t1 = t1 & p[k*GROUP_W+m];
        gg[k] = gg[k] | t1;
      end
    end
  end
  // Stage 2a: every group carry as a flat sum of products of cin, Gk and Pk
  always_comb begin
    gc = '0;
    t2 = 1'b0;
    a2 = 1'b0;
    gc[0] = s1_cin;
    for (int k = 1; k <= NG; k++) begin
      t2 = s1_cin;
      for (int j = 0; j < k; j++) t2 = t2 & s1_gp[j];
      a2 = t2;
      for (int j = 0; j < k; j++) begin
        t2 = s1_gg[j];
        for (int m = j + 1; m < k; m++) t2 = t2 & s1_gp[m];
        a2 = a2 | t2;
      end
      gc[k] = a2;
    end
  end
  // Stage 2b: in-group bit carries expanded from the group's incoming carry
  always_comb begin
    bc = '0;
    t3 = 1'b0;
    a3 = 1'b0;
    for (int k = 0; k < NG; k++) begin
      for (int j = 0; j < GROUP_W; j++) begin
        t3 = gc[k];
        for (int m = 0; m < j; m++) t3 = t3 & s1_p[k*GROUP_W+m];
        a3 = t3;
        for (int m = 0; m < j; m++) begin
          t3 = s1_g[k*GROUP_W+m];
          for (int n = m + 1; n < j; n++) t3 = t3 & s1_p[k*GROUP_W+n];
          a3 = a3 | t3;
        end
        bc[k*GROUP_W+j] = a3;
      end
    end
  end
`ifdef CLA_OVERFLOW_EN
  logic ovf_q;
  assign bus.overflow = ovf_q;
  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else if (s2_adv && s1_valid) ovf_q <= bc[WIDTH-1] ^ gc[NG];
  end
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_cin <= 1'b0;
      s1_p <= '0;
      s1_g <= '0;
      s1_gp <= '0;
      s1_gg <= '0;
      s2_valid <= 1'b0;
      sum_q <= '0;
      cout_q <= 1'b0;
    end else begin
      if (s1_adv) s1_valid <= bus.in_valid;
      if (s1_adv && bus.in_valid) begin
        s1_p <= p;
        s1_g <= g;
        s1_gp <= gp;
        s1_gg <= gg;
        s1_cin <= bus.cin;
      end
      if (s2_adv) s2_valid <= s1_valid;
      if (s2_adv && s1_valid) begin
        sum_q <= s1_p ^ bc;
        cout_q <= gc[NG];
      end
    end
  end
endmodule
